// File: rtl/multi_timer.sv
// multi_timer: NUM_CH down-counters stepped by a shared prescaler tick, exposed as a bus register file.
// Latency: reads, irq and expired_pulse are combinational; register updates land on the next clk edge.
// Backpressure: none; one write accepted per wr_en cycle. Define MULTI_TIMER_CASCADE_EN for chained channels.
module multi_timer #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int PRESCALE    = 50000,
  parameter int PRE_WIDTH   = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [1:0]             reg_addr,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  input  logic                   wr_en,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]      expired_pulse,
  output logic                   irq
);

  logic [PRE_WIDTH-1:0]   pre_cnt;
  logic                   tick;
  logic [COUNT_WIDTH-1:0] count  [NUM_CH];
  logic [COUNT_WIDTH-1:0] reload [NUM_CH];
  logic [NUM_CH-1:0]      run;
  logic [NUM_CH-1:0]      periodic;
  logic [NUM_CH-1:0]      irq_en;
  logic [NUM_CH-1:0]      expired;
`ifdef MULTI_TIMER_CASCADE_EN
  logic [NUM_CH-1:0]      cascade;
`endif
  logic [NUM_CH-1:0]      ch_hit;
  logic [NUM_CH-1:0]      wr_count;
  logic [NUM_CH-1:0]      wr_ctrl;
  logic [NUM_CH-1:0]      wr_status;
  logic [NUM_CH-1:0]      step;

  // Free-running prescaler; tick is the single cycle spent at zero. Bus writes never touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= PRE_WIDTH'(PRESCALE - 1);
    end else if (pre_cnt == '0) begin
      pre_cnt <= PRE_WIDTH'(PRESCALE - 1);
    end else begin
      pre_cnt <= pre_cnt - PRE_WIDTH'(1);
    end
  end

  assign tick = (pre_cnt == '0);

  // Address decode: out-of-range channels match nothing, reg_addr 3 is never a write target.
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (ch_sel == CH_W'(i));
    end
    wr_count  = (wr_en && reg_addr == 2'd0) ? ch_hit : '0;
    wr_ctrl   = (wr_en && reg_addr == 2'd1) ? ch_hit : '0;
    wr_status = (wr_en && reg_addr == 2'd2) ? ch_hit : '0;
  end

  // Step enables and expiry pulses; a COUNT/CTRL write to a channel swallows its step that cycle.
  always_comb begin
    logic src;
`ifdef MULTI_TIMER_CASCADE_EN
    logic prev;
    prev = 1'b0;
`endif
    step          = '0;
    expired_pulse = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      src = tick;
`ifdef MULTI_TIMER_CASCADE_EN
      if (i > 0 && cascade[i]) src = prev;
`endif
      step[i]          = src && run[i] && !wr_count[i] && !wr_ctrl[i];
      expired_pulse[i] = step[i] && (count[i] == '0);
`ifdef MULTI_TIMER_CASCADE_EN
      prev = expired_pulse[i];
`endif
    end
  end

  // Per-channel state: bus writes first, then counting; a set of expired beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        reload[i] <= '0;
      end
      run      <= '0;
      periodic <= '0;
      irq_en   <= '0;
      expired  <= '0;
`ifdef MULTI_TIMER_CASCADE_EN
      cascade  <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_count[i]) begin
          count[i]   <= wr_data;
          reload[i]  <= wr_data;
          run[i]     <= 1'b1;
          expired[i] <= 1'b0;
        end else if (wr_ctrl[i]) begin
          run[i]      <= wr_data[0];
          periodic[i] <= wr_data[1];
          irq_en[i]   <= wr_data[2];
`ifdef MULTI_TIMER_CASCADE_EN
          cascade[i]  <= wr_data[3];
`endif
        end else begin
          if (step[i]) begin
            if (count[i] != '0) begin
              count[i] <= count[i] - COUNT_WIDTH'(1);
            end else begin
              expired[i] <= 1'b1;
              if (periodic[i]) count[i] <= reload[i];
              else             run[i]   <= 1'b0;
            end
          end
          if (wr_status[i] && wr_data[0] && !expired_pulse[i]) expired[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational read of the addressed register; unmapped addresses read 0.
  always_comb begin
    logic [3:0] ctrl_rd;
    rd_data = '0;
    ctrl_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
`ifdef MULTI_TIMER_CASCADE_EN
        ctrl_rd = {cascade[i], irq_en[i], periodic[i], run[i]};
`else
        ctrl_rd = {1'b0, irq_en[i], periodic[i], run[i]};
`endif
        case (reg_addr)
          2'd0:    rd_data = count[i];
          2'd1:    rd_data = COUNT_WIDTH'(ctrl_rd);
          2'd2:    rd_data = COUNT_WIDTH'(expired[i]);
          default: rd_data = '0;
        endcase
      end
    end
  end

  assign irq = |(expired & irq_en);

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel successor to the single millisecond timer; NUM_CH independent down-counters share one free-running prescaler that generates a tick every PRESCALE clocks.
- Each channel supports one-shot or periodic (auto-reload) mode, a sticky expired flag, a one-cycle expiry pulse and a maskable interrupt.
- Sits on the processor peripheral bus as a small register file selected by channel and register address.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- COUNT_WIDTH, 8, width of count/reload registers and data bus (>= 4).
- PRESCALE, 50000, clock cycles per tick (50000 = 1 ms at 50 MHz); must be >= 2.
- PRE_WIDTH, 16, prescaler counter width; must satisfy 2^PRE_WIDTH >= PRESCALE.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- ch_sel  input  $clog2(NUM_CH) (min 1)  channel addressed by the access.
- reg_addr  input  2  register: 0 COUNT, 1 CTRL, 2 STATUS, 3 reserved.
- wr_data  input  COUNT_WIDTH  write data.
- wr_en  input  1  write strobe, one write per asserted cycle.
- rd_data  output  COUNT_WIDTH  combinational read of the addressed register.
- expired_pulse  output  NUM_CH  one-cycle pulse per channel on expiry.
- irq  output  1  OR over channels of (status.expired & ctrl.irq_en).

Behaviour:
- Reset (reset=0, async): prescaler=PRESCALE-1, tick=0, all count/reload/ctrl/status=0, expired_pulse=0, irq=0.
- Prescaler: free-running down-counter; at 0 it reloads PRESCALE-1 and tick is high for that one cycle. Never restarted by bus writes.
- CTRL bits: [0] run, [1] periodic, [2] irq_en, [3] cascade (see optional feature); other bits read 0.
- COUNT write: count <= wr_data, reload <= wr_data, run <= 1, status.expired <= 0; periodic/irq_en unchanged.
- COUNT read: current count value.
- CTRL write: updates bits [3:0]. run=0 freezes count; run=1 resumes from the held count.
- STATUS: bit0 = sticky expired flag; writing 1 to bit0 clears it, writing 0 has no effect.
- Channel step, on a tick with run=1:
  - count != 0: count <= count-1.
  - count == 0: expired_pulse[i]=1 for one cycle and status.expired <= 1.
  - Then, if periodic: count <= reload, run stays 1. If one-shot: run <= 0, count stays 0.
  - A COUNT load of N therefore expires on tick N+1 after the write.
- Priority and collisions:
  - A COUNT or CTRL write to a channel in the same cycle as its tick wins; that tick is skipped for that channel.
  - A STATUS clear in the same cycle as an expiry: set wins.
- Access decoding: ch_sel >= NUM_CH or reg_addr=3 reads 0 and writes are ignored.
- irq is registered-free (combinational from status/ctrl); it deasserts the cycle after the clear write.
- Reset asserted mid-count aborts immediately; after release all channels are idle until re-armed.

Optional Feature:
- Macro: MULTI_TIMER_CASCADE_EN.
- Defined: for channel i>0 with ctrl.cascade=1, the channel steps on expired_pulse[i-1] instead of the prescaler tick; the rest of the behaviour is identical, giving a chained counter. Channel 0 ignores its cascade bit.
- Undefined: CTRL bit3 is not stored, reads 0 and is ignored; all channels step on the prescaler tick.

Test Plan:
- PRESCALE=4, NUM_CH=4: write COUNT ch0=2 one-shot -> expired_pulse[0] exactly on the 3rd tick after the write (ticks 4 cycles apart); STATUS reads 1, CTRL.run reads 0, COUNT reads 0.
- ch1 periodic, COUNT=1, irq_en=1 -> pulses every 2 ticks (8 cycles) across 5 periods; irq stays high until STATUS is written 1, low next cycle, re-asserts on next expiry.
- Same-cycle STATUS clear and expiry on ch2 -> STATUS remains 1. COUNT write coinciding with a tick -> loaded value held, no decrement that tick.
- Mid-count, CTRL run=0 for 10 ticks, then run=1 -> count frozen at same value, expiry delayed by exactly 10 ticks.
- Assert reset asynchronously (between clk edges) while ch0..3 are counting -> all outputs 0 immediately, rd_data 0 for all registers, no pulses after release.
- With MULTI_TIMER_CASCADE_EN: ch0 periodic COUNT=1, ch1 cascade COUNT=2 one-shot -> ch1 expires on the 3rd ch0 pulse (tick 6). Without the macro, CTRL bit3 reads back 0.
